cfo_packet_tx: RTL and testbench



---
 rtl/cfo_packet_tx.sv | 223 ++++++++++++++++++++++
 tb/tb_cfo_packet_tx.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfo_packet_tx.sv
// Packet/EWM transmitter: serialises CFO packet and EWM requests into a 16-bit K28.5-idled word stream.
// Latency: request sampled at T, first word (EWM or w0) on tx_data at T+2; all outputs registered.
// Backpressure: none; a request arriving while its pending slot is occupied is dropped and counted.
// Optional macro CFO_PKT_CRC_EN appends a CRC-16-CCITT word and makes packets 9 words long.
module cfo_packet_tx #(
    parameter logic [15:0] IDLE_WORD = 16'h50BC,
    parameter logic [15:0] EWM_WORD  = 16'h001C,
    parameter logic [2:0]  SUBSYS_ID = 3'd1
) (
    input  logic        serdesclk,
    input  logic        serdesclk_reset,
    input  logic        startCFO,
    input  logic [3:0]  CFO_packet_type,
    input  logic [31:0] event_mode,
    input  logic [47:0] EWtag,
    input  logic        startEWM,
    output logic [15:0] tx_data,
    output logic [1:0]  tx_kchar,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic [31:0] pkt_count,
    output logic [15:0] drop_count,
    output logic        overflow
);

`ifdef CFO_PKT_CRC_EN
    localparam logic [15:0] BYTE_CNT = 16'h0012;
    typedef enum logic [1:0] {ST_IDLE, ST_EWM, ST_PKT, ST_CRC} state_t;
`else
    localparam logic [15:0] BYTE_CNT = 16'h0010;
    typedef enum logic [1:0] {ST_IDLE, ST_EWM, ST_PKT} state_t;
`endif

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        pkt_pend_q, pkt_pend_d;
    logic [3:0]  slot_type_q, slot_type_d;
    logic [47:0] slot_tag_q, slot_tag_d;
    logic [31:0] slot_mode_q, slot_mode_d;
    logic        ewm_pend_q, ewm_pend_d;
    logic [3:0]  wk_type_q, wk_type_d;
    logic [47:0] wk_tag_q, wk_tag_d;
    logic [31:0] wk_mode_q, wk_mode_d;
    logic [15:0] tx_data_q, tx_data_d;
    logic [1:0]  tx_kchar_q, tx_kchar_d;
    logic        tx_sop_q, tx_sop_d;
    logic        tx_eop_q, tx_eop_d;
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [15:0] drop_count_q, drop_count_d;
    logic        overflow_q, overflow_d;
`ifdef CFO_PKT_CRC_EN
    logic [15:0] crc_q, crc_d;

    // One 16-bit word through CRC-16-CCITT, MSB first.
    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in, input logic [15:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int b = 15; b >= 0; b--) begin
            if (c[15] ^ data[b]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction
`endif

    logic        boundary, take_ewm, take_pkt, type_ok, cfo_ok, cfo_drop, ewm_drop;
    logic [15:0] pkt_word;
    logic [16:0] drop_sum;

    // Next-state: word-boundary arbitration, word generation, request capture and counters.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pkt_pend_d   = pkt_pend_q;
        slot_type_d  = slot_type_q;
        slot_tag_d   = slot_tag_q;
        slot_mode_d  = slot_mode_q;
        ewm_pend_d   = ewm_pend_q;
        wk_type_d    = wk_type_q;
        wk_tag_d     = wk_tag_q;
        wk_mode_d    = wk_mode_q;
        pkt_word     = 16'h0000;
`ifdef CFO_PKT_CRC_EN
        crc_d        = crc_q;
        // The last data word hands over to the CRC word, so it is not a boundary.
        boundary     = (state_q != ST_PKT);
`else
        boundary     = (state_q != ST_PKT) || (idx_q == 3'd7);
`endif
        take_ewm     = boundary && ewm_pend_q;
        take_pkt     = boundary && !ewm_pend_q && pkt_pend_q;

        if (take_ewm) begin
            state_d = ST_EWM;
        end else if (take_pkt) begin
            state_d   = ST_PKT;
            idx_d     = 3'd0;
            wk_type_d = slot_type_q;
            wk_tag_d  = slot_tag_q;
            wk_mode_d = slot_mode_q;
        end else if (boundary) begin
            state_d = ST_IDLE;
`ifdef CFO_PKT_CRC_EN
        end else if (idx_q == 3'd7) begin
            state_d = ST_CRC;
`endif
        end else begin
            idx_d = idx_q + 3'd1;
        end

        case (idx_d)
            3'd0:    pkt_word = BYTE_CNT;
            3'd1:    pkt_word = {1'b1, 4'b0000, SUBSYS_ID, wk_type_d, 4'h0};
            3'd2:    pkt_word = wk_tag_d[15:0];
            3'd3:    pkt_word = wk_tag_d[31:16];
            3'd4:    pkt_word = wk_tag_d[47:32];
            3'd5:    pkt_word = wk_mode_d[15:0];
            3'd6:    pkt_word = wk_mode_d[31:16];
            default: pkt_word = 16'h0000;
        endcase

        tx_data_d  = IDLE_WORD;
        tx_kchar_d = 2'b01;
        tx_sop_d   = 1'b0;
        tx_eop_d   = 1'b0;
        case (state_d)
            ST_EWM: tx_data_d = EWM_WORD;
            ST_PKT: begin
                tx_data_d  = pkt_word;
                tx_kchar_d = 2'b00;
                tx_sop_d   = (idx_d == 3'd0);
`ifdef CFO_PKT_CRC_EN
                crc_d      = crc16_word((idx_d == 3'd0) ? 16'hFFFF : crc_q, pkt_word);
`else
                tx_eop_d   = (idx_d == 3'd7);
`endif
            end
`ifdef CFO_PKT_CRC_EN
            ST_CRC: begin
                tx_data_d  = crc_q;
                tx_kchar_d = 2'b00;
                tx_eop_d   = 1'b1;
            end
`endif
            default: ;
        endcase
        pkt_count_d = pkt_count_q + {31'd0, tx_eop_d};

        // The slot is freed before capture so a transfer and a new request can share a cycle.
        if (take_pkt) pkt_pend_d = 1'b0;
        type_ok = (CFO_packet_type == 4'd1) || (CFO_packet_type == 4'd2) || (CFO_packet_type == 4'd3);
        cfo_ok  = startCFO && type_ok && !pkt_pend_d;
        cfo_drop = startCFO && !cfo_ok;
        if (cfo_ok) begin
            pkt_pend_d  = 1'b1;
            slot_type_d = CFO_packet_type;
            slot_tag_d  = EWtag;
            slot_mode_d = event_mode;
        end
        ewm_drop   = startEWM && ewm_pend_q && !take_ewm;
        ewm_pend_d = (ewm_pend_q && !take_ewm) || startEWM;

        drop_sum     = {1'b0, drop_count_q} + {16'd0, cfo_drop} + {16'd0, ewm_drop};
        drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        overflow_d   = overflow_q || cfo_drop || ewm_drop;
    end

    // FSM and all registered outputs/state; reset abandons any packet in flight.
    always_ff @(posedge serdesclk) begin
        if (serdesclk_reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= 3'd0;
            pkt_pend_q   <= 1'b0;
            slot_type_q  <= 4'd0;
            slot_tag_q   <= 48'd0;
            slot_mode_q  <= 32'd0;
            ewm_pend_q   <= 1'b0;
            wk_type_q    <= 4'd0;
            wk_tag_q     <= 48'd0;
            wk_mode_q    <= 32'd0;
            tx_data_q    <= IDLE_WORD;
            tx_kchar_q   <= 2'b01;
            tx_sop_q     <= 1'b0;
            tx_eop_q     <= 1'b0;
            pkt_count_q  <= 32'd0;
            drop_count_q <= 16'd0;
            overflow_q   <= 1'b0;
`ifdef CFO_PKT_CRC_EN
            crc_q        <= 16'hFFFF;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pkt_pend_q   <= pkt_pend_d;
            slot_type_q  <= slot_type_d;
            slot_tag_q   <= slot_tag_d;
            slot_mode_q  <= slot_mode_d;
            ewm_pend_q   <= ewm_pend_d;
            wk_type_q    <= wk_type_d;
            wk_tag_q     <= wk_tag_d;
            wk_mode_q    <= wk_mode_d;
            tx_data_q    <= tx_data_d;
            tx_kchar_q   <= tx_kchar_d;
            tx_sop_q     <= tx_sop_d;
            tx_eop_q     <= tx_eop_d;
            pkt_count_q  <= pkt_count_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
`ifdef CFO_PKT_CRC_EN
            crc_q        <= crc_d;
`endif
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_kchar   = tx_kchar_q;
    assign tx_sop     = tx_sop_q;
    assign tx_eop     = tx_eop_q;
    assign pkt_count  = pkt_count_q;
    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_cfo_packet_tx.sv
// Bench for cfo_packet_tx: directed scenarios plus a randomized run against a transaction-level model.
// Honours CFO_PKT_CRC_EN the same way as the design (9-word packets, w0 = 16'h0012).
module tb_cfo_packet_tx;
    localparam logic [15:0] IDLE_W = 16'h50BC;
    localparam logic [15:0] EWM_W  = 16'h001C;
`ifdef CFO_PKT_CRC_EN
    localparam int NW = 9;
`else
    localparam int NW = 8;
`endif

    typedef struct packed {
        logic [3:0]  typ;
        logic [47:0] tag;
        logic [31:0] mode;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_cfo = 1'b0;
    logic [3:0]  ptype = 4'd0;
    logic [31:0] emode = 32'd0;
    logic [47:0] ewtag = 48'd0;
    logic        start_ewm = 1'b0;
    logic [15:0] tx_data;
    logic [1:0]  tx_kchar;
    logic        tx_sop, tx_eop;
    logic [31:0] pkt_count;
    logic [15:0] drop_count;
    logic        overflow;

    int n_checks = 0;
    int n_fail = 0;
    int exp_pkts = 0;
    int exp_drops = 0;
    int exp_ewm = 0;

    // monitor state
    logic [143:0] cap_q[$];
    int           cap_len_q[$];
    logic [143:0] cur;
    int           cur_len = 0;
    bit           collecting = 0;
    int           sop_cnt = 0;
    int           ewm_cnt = 0;

    cfo_packet_tx dut (
        .serdesclk(clk), .serdesclk_reset(rst), .startCFO(start_cfo),
        .CFO_packet_type(ptype), .event_mode(emode), .EWtag(ewtag), .startEWM(start_ewm),
        .tx_data(tx_data), .tx_kchar(tx_kchar), .tx_sop(tx_sop), .tx_eop(tx_eop),
        .pkt_count(pkt_count), .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    // Reference CRC-16-CCITT: shift data and register together, one bit per step.
    function automatic logic [15:0] ref_crc(input logic [15:0] words [8]);
        logic [15:0] c, d;
        bit fb;
        c = 16'hFFFF;
        for (int w = 0; w < 8; w++) begin
            d = words[w];
            for (int k = 0; k < 16; k++) begin
                fb = c[15] ^ d[15];
                c = c << 1;
                d = d << 1;
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    function automatic logic [15:0] exp_word(input pkt_t p, input int i);
        logic [15:0] w [8];
        w[0] = (NW == 9) ? 16'h0012 : 16'h0010;
        w[1] = 16'h8000 | (16'(1) << 8) | (16'(p.typ) << 4);
        w[2] = p.tag[15:0];
        w[3] = p.tag[31:16];
        w[4] = p.tag[47:32];
        w[5] = p.mode[15:0];
        w[6] = p.mode[31:16];
        w[7] = 16'h0000;
        if (i < 8) return w[i];
        return ref_crc(w);
    endfunction

    function automatic logic [143:0] exp_vec(input pkt_t p);
        logic [143:0] v;
        v = '0;
        for (int i = 0; i < NW; i++) v[i*16 +: 16] = exp_word(p, i);
        return v;
    endfunction

    // Collects every emitted packet (sop..eop) and counts EWM words.
    always @(negedge clk) begin
        if (rst) begin
            collecting = 0;
        end else begin
            if (tx_sop) begin
                collecting = 1;
                cur_len = 0;
                cur = '0;
                sop_cnt++;
            end
            if (collecting) begin
                if (cur_len < 9) cur[cur_len*16 +: 16] = tx_data;
                cur_len++;
                if (tx_eop) begin
                    cap_q.push_back(cur);
                    cap_len_q.push_back(cur_len);
                    collecting = 0;
                end
            end
            if (tx_data == EWM_W && tx_kchar == 2'b01) ewm_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pkt(input pkt_t p);
        ptype = p.typ;
        ewtag = p.tag;
        emode = p.mode;
        start_cfo = 1'b1;
    endtask

    function automatic pkt_t rand_pkt();
        pkt_t p;
        p.typ  = 4'($urandom_range(1, 3));
        p.tag  = {16'($urandom), $urandom};
        p.mode = $urandom;
        return p;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            n_checks++;
            if (tx_data !== IDLE_W || tx_kchar !== 2'b01 || tx_sop !== 1'b0 || tx_eop !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: data=%h k=%b sop=%b eop=%b, want %h 01 0 0", c, tx_data, tx_kchar, tx_sop, tx_eop, IDLE_W);
            end
            n_checks++;
            if (pkt_count !== 32'd0 || drop_count !== 16'd0 || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_counters: pkt=%0d drop=%0d ovf=%b, want 0 0 0", pkt_count, drop_count, overflow);
            end
        end
    endtask

    task automatic test_hb();
        pkt_t p;
        p.typ = 4'd1; p.tag = 48'h0000_0000_0005; p.mode = 32'd1;
        drive_pkt(p);
        step();
        start_cfo = 1'b0;
        for (int i = 0; i < NW; i++) begin
            step();
            n_checks++;
            if (tx_data !== exp_word(p, i) || tx_kchar !== 2'b00 || tx_sop !== (i == 0) || tx_eop !== (i == NW - 1)) begin
                n_fail++;
                $display("FAIL hb_w%0d: data=%h k=%b sop=%b eop=%b, want %h 00 %0d %0d", i, tx_data, tx_kchar, tx_sop, tx_eop, exp_word(p, i), i == 0, i == NW - 1);
            end
        end
        step();
        exp_pkts++;
        n_checks++;
        if (pkt_count !== 32'(exp_pkts) || tx_data !== IDLE_W) begin
            n_fail++;
            $display("FAIL hb_after: pkt_count=%0d data=%h, want %0d %h", pkt_count, tx_data, exp_pkts, IDLE_W);
        end
    endtask

    task automatic test_ewm_mid_packet();
        pkt_t p;
        p = rand_pkt();
        drive_pkt(p);
        step();
        start_cfo = 1'b0;
        for (int i = 0; i < NW; i++) begin
            step();
            start_ewm = 1'b0;
            n_checks++;
            if (tx_data !== exp_word(p, i) || tx_kchar !== 2'b00 || tx_eop !== (i == NW - 1)) begin
                n_fail++;
                $display("FAIL ewm_mid_w%0d: data=%h k=%b eop=%b, want %h 00 %0d", i, tx_data, tx_kchar, tx_eop, exp_word(p, i), i == NW - 1);
            end
            if (i == 3) start_ewm = 1'b1;
        end
        step();
        exp_pkts++;
        exp_ewm++;
        n_checks++;
        if (tx_data !== EWM_W || tx_kchar !== 2'b01) begin
            n_fail++;
            $display("FAIL ewm_mid_marker: data=%h k=%b, want %h 01", tx_data, tx_kchar, EWM_W);
        end
        step();
        n_checks++;
        if (tx_data !== IDLE_W || tx_kchar !== 2'b01 || pkt_count !== 32'(exp_pkts)) begin
            n_fail++;
            $display("FAIL ewm_mid_idle: data=%h k=%b pkt=%0d, want %h 01 %0d", tx_data, tx_kchar, pkt_count, IDLE_W, exp_pkts);
        end
    endtask

    task automatic test_back_to_back();
        pkt_t p0, p1;
        p0 = rand_pkt();
        p1 = rand_pkt();
        drive_pkt(p0);
        start_ewm = 1'b1;
        step();
        start_cfo = 1'b0;
        start_ewm = 1'b0;
        step();
        exp_ewm++;
        n_checks++;
        if (tx_data !== EWM_W || tx_kchar !== 2'b01 || tx_sop !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ewm_first: data=%h k=%b sop=%b, want %h 01 0", tx_data, tx_kchar, tx_sop, EWM_W);
        end
        for (int i = 0; i < NW; i++) begin
            step();
            start_cfo = 1'b0;
            n_checks++;
            if (tx_data !== exp_word(p0, i) || tx_sop !== (i == 0) || tx_eop !== (i == NW - 1)) begin
                n_fail++;
                $display("FAIL b2b_p0_w%0d: data=%h sop=%b eop=%b, want %h %0d %0d", i, tx_data, tx_sop, tx_eop, exp_word(p0, i), i == 0, i == NW - 1);
            end
            if (i == 2) drive_pkt(p1);
        end
        for (int i = 0; i < NW; i++) begin
            step();
            n_checks++;
            if (tx_data !== exp_word(p1, i) || tx_sop !== (i == 0) || tx_eop !== (i == NW - 1)) begin
                n_fail++;
                $display("FAIL b2b_p1_w%0d: data=%h sop=%b eop=%b, want %h %0d %0d", i, tx_data, tx_sop, tx_eop, exp_word(p1, i), i == 0, i == NW - 1);
            end
        end
        exp_pkts += 2;
        step();
        n_checks++;
        if (tx_data !== IDLE_W || pkt_count !== 32'(exp_pkts)) begin
            n_fail++;
            $display("FAIL b2b_after: data=%h pkt=%0d, want %h %0d", tx_data, pkt_count, IDLE_W, exp_pkts);
        end
    endtask

    task automatic test_overrun();
        pkt_t p [3];
        pkt_t bad;
        int base;
        base = cap_q.size();
        for (int k = 0; k < 3; k++) p[k] = rand_pkt();
        for (int k = 0; k < 3; k++) begin
            drive_pkt(p[k]);
            step();
        end
        start_cfo = 1'b0;
        start_ewm = 1'b1;
        step();
        step();
        start_ewm = 1'b0;
        repeat (40) step();
        exp_pkts += 2;
        exp_drops += 2;
        exp_ewm++;
        n_checks++;
        if (cap_q.size() !== base + 2 || pkt_count !== 32'(exp_pkts)) begin
            n_fail++;
            $display("FAIL overrun_pkts: captured=%0d pkt_count=%0d, want %0d %0d", cap_q.size() - base, pkt_count, 2, exp_pkts);
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (cap_q[base+k] !== exp_vec(p[k]) || cap_len_q[base+k] !== NW) begin
                    n_fail++;
                    $display("FAIL overrun_pkt%0d: got %h len %0d, want %h len %0d", k, cap_q[base+k], cap_len_q[base+k], exp_vec(p[k]), NW);
                end
            end
        end
        n_checks++;
        if (drop_count !== 16'(exp_drops) || overflow !== 1'b1 || ewm_cnt !== exp_ewm) begin
            n_fail++;
            $display("FAIL overrun_drops: drop=%0d ovf=%b ewm=%0d, want %0d 1 %0d", drop_count, overflow, ewm_cnt, exp_drops, exp_ewm);
        end
        bad = rand_pkt();
        bad.typ = 4'd4;
        drive_pkt(bad);
        step();
        start_cfo = 1'b0;
        repeat (15) step();
        exp_drops++;
        n_checks++;
        if (drop_count !== 16'(exp_drops) || pkt_count !== 32'(exp_pkts) || cap_q.size() !== base + 2) begin
            n_fail++;
            $display("FAIL bad_type: drop=%0d pkt=%0d captured=%0d, want %0d %0d %0d", drop_count, pkt_count, cap_q.size() - base, exp_drops, exp_pkts, 2);
        end
    endtask

    task automatic test_reset_mid_packet();
        pkt_t p;
        p = rand_pkt();
        drive_pkt(p);
        step();
        start_cfo = 1'b0;
        repeat (5) step();
        n_checks++;
        if (tx_data !== exp_word(p, 4)) begin
            n_fail++;
            $display("FAIL rst_mid_w4: data=%h, want %h", tx_data, exp_word(p, 4));
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_pkts = 0;
        exp_drops = 0;
        n_checks++;
        if (tx_data !== IDLE_W || tx_kchar !== 2'b01 || tx_sop !== 1'b0 || tx_eop !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_idle: data=%h k=%b sop=%b eop=%b, want %h 01 0 0", tx_data, tx_kchar, tx_sop, tx_eop, IDLE_W);
        end
        n_checks++;
        if (pkt_count !== 32'd0 || drop_count !== 16'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_counters: pkt=%0d drop=%0d ovf=%b, want 0 0 0", pkt_count, drop_count, overflow);
        end
        for (int c = 0; c < 12; c++) begin
            step();
            n_checks++;
            if (tx_eop !== 1'b0 || tx_data !== IDLE_W) begin
                n_fail++;
                $display("FAIL rst_mid_quiet cyc%0d: data=%h eop=%b, want %h 0", c, tx_data, tx_eop, IDLE_W);
            end
        end
    endtask

    task automatic test_random();
        pkt_t exp_q[$];
        pkt_t p;
        int base, target;
        base = cap_q.size();
        target = sop_cnt;
        for (int n = 0; n < 25; n++) begin
            p = rand_pkt();
            drive_pkt(p);
            if (ewm_cnt == exp_ewm && $urandom_range(0, 2) == 0) begin
                start_ewm = 1'b1;
                exp_ewm++;
            end
            exp_q.push_back(p);
            target++;
            step();
            start_cfo = 1'b0;
            start_ewm = 1'b0;
            for (int k = 0; k < 60 && sop_cnt < target; k++) step();
            n_checks++;
            if (sop_cnt < target) begin
                n_fail++;
                $display("FAIL rand_sop_timeout pkt%0d: sops=%0d, want %0d", n, sop_cnt, target);
            end
            repeat ($urandom_range(0, 10)) step();
        end
        repeat (40) step();
        exp_pkts += 25;
        n_checks++;
        if (cap_q.size() !== base + 25) begin
            n_fail++;
            $display("FAIL rand_count: captured=%0d, want 25", cap_q.size() - base);
        end else begin
            for (int n = 0; n < 25; n++) begin
                n_checks++;
                if (cap_q[base+n] !== exp_vec(exp_q[n]) || cap_len_q[base+n] !== NW) begin
                    n_fail++;
                    $display("FAIL rand_pkt%0d: got %h len %0d, want %h len %0d", n, cap_q[base+n], cap_len_q[base+n], exp_vec(exp_q[n]), NW);
                end
            end
        end
        n_checks++;
        if (pkt_count !== 32'(exp_pkts) || drop_count !== 16'(exp_drops) || overflow !== 1'b0 || ewm_cnt !== exp_ewm) begin
            n_fail++;
            $display("FAIL rand_totals: pkt=%0d drop=%0d ovf=%b ewm=%0d, want %0d %0d 0 %0d", pkt_count, drop_count, overflow, ewm_cnt, exp_pkts, exp_drops, exp_ewm);
        end
    endtask

    initial begin
        test_reset();
        test_hb();
        test_ewm_mid_packet();
        test_back_to_back();
        test_overrun();
        test_reset_mid_packet();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
